// File: rtl/config_loader.sv
// Purpose: clears a serial configuration chain, then shifts a byte stream into it MSB first and checks the chain tail.
// Latency: first shift one cycle after a byte is accepted, one bit per cycle, DONE on the edge of the last shift.
// Backpressure: byte_ready rises only once the shift register is empty or on its last bit, and only while unloaded bits remain.
module config_loader #(
    parameter int CHAIN_LENGTH = 5120,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       grid_config_in,
    output logic       grid_config_enable,
    output logic       grid_config_nreset,
    input  logic       grid_config_out,
    output logic       busy,
    output logic       done,
    output logic       fault
);
    localparam int CW = $clog2(CHAIN_LENGTH + 1);
    localparam int KW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CW-1:0] CHAIN_INIT = CW'(CHAIN_LENGTH);
    localparam logic [KW-1:0] CLEAR_LAST = KW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] load_cnt;
    logic [7:0]    sr;
    logic [3:0]    sr_cnt;
    logic [KW-1:0] clr_cnt;
    logic          gnr_q;
    logic          fault_q;
    logic          shift;
    logic          accept;
    logic [3:0]    take;

    // load_cnt counts bits not yet captured into sr; bit_cnt counts bits not yet shifted out
    assign shift      = (state == LOAD) && (sr_cnt != 4'd0);
    assign byte_ready = (state == LOAD) && (load_cnt != '0) && (sr_cnt <= 4'd1);
    assign accept     = byte_ready && byte_valid;
    assign take       = (int'(load_cnt) >= 8) ? 4'd8 : 4'(load_cnt);

    assign grid_config_enable = shift;
    assign grid_config_in     = shift & sr[7];
    assign grid_config_nreset = gnr_q;
    assign busy               = (state == CLEAR) || (state == LOAD);
    assign done               = (state == DONE);
    assign fault              = fault_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            load_cnt <= '0;
            sr       <= 8'd0;
            sr_cnt   <= 4'd0;
            clr_cnt  <= '0;
            gnr_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    gnr_q <= 1'b1;
                    if (start) begin
                        state    <= CLEAR;
                        gnr_q    <= 1'b0;
                        fault_q  <= 1'b0;
                        bit_cnt  <= CHAIN_INIT;
                        load_cnt <= CHAIN_INIT;
                        clr_cnt  <= '0;
                        sr_cnt   <= 4'd0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLEAR_LAST) begin
                        state <= LOAD;
                        gnr_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (shift) begin
                        bit_cnt <= bit_cnt - 1'b1;
                        // chain was just cleared, so any 1 at the tail means a broken chain
                        if (grid_config_out) fault_q <= 1'b1;
                        if (bit_cnt == CW'(1)) state <= DONE;
                    end
                    if (accept) begin
                        sr       <= byte_data;
                        sr_cnt   <= take;
                        load_cnt <= load_cnt - CW'(take);
                    end else if (shift) begin
                        sr     <= {sr[6:0], 1'b0};
                        sr_cnt <= sr_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 16-bit chain instance for most scenarios and a 12-bit one for the partial final byte.
module tb_config_loader;
    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready, grid_config_in, grid_config_enable, grid_config_nreset;
    logic       grid_config_out = 1'b0;
    logic       busy, done, fault;

    logic       start12 = 1'b0;
    logic [7:0] bd12 = 8'd0;
    logic       bv12 = 1'b0;
    logic       br12, gci12, gce12, gcn12, busy12, done12, fault12;
    logic       gco12 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    config_loader #(.CHAIN_LENGTH(16), .CLEAR_CYCLES(4)) u_dut (
        .clock(clock), .nreset(nreset), .start(start), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .grid_config_in(grid_config_in),
        .grid_config_enable(grid_config_enable), .grid_config_nreset(grid_config_nreset),
        .grid_config_out(grid_config_out), .busy(busy), .done(done), .fault(fault)
    );

    config_loader #(.CHAIN_LENGTH(12), .CLEAR_CYCLES(4)) u_dut12 (
        .clock(clock), .nreset(nreset), .start(start12), .byte_data(bd12),
        .byte_valid(bv12), .byte_ready(br12), .grid_config_in(gci12),
        .grid_config_enable(gce12), .grid_config_nreset(gcn12),
        .grid_config_out(gco12), .busy(busy12), .done(done12), .fault(fault12)
    );

    // Observation at the falling edge; tasks read these counters #1 after a falling edge.
    int   cyc = 0, shifts = 0, nr_low = 0, done_cyc = 0, fault_rise_at = -1, fault_target = 0;
    logic fault_prev = 1'b0, done_prev = 1'b0;
    logic bits_q[$];
    int   en_q[$];
    logic bits12_q[$];
    int   acc12 = 0;

    always @(negedge clock) begin
        cyc++;
        if (nreset && !grid_config_nreset) nr_low++;
        if (fault && !fault_prev) fault_rise_at = shifts;
        fault_prev = fault;
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
        if (grid_config_enable) begin
            bits_q.push_back(grid_config_in);
            en_q.push_back(cyc);
            shifts++;
            grid_config_out = (fault_target != 0) && (shifts == fault_target);
        end else begin
            grid_config_out = 1'b0;
        end
        if (gce12) bits12_q.push_back(gci12);
        if (bv12 && br12) acc12++;
    end

    task automatic send_byte(input logic [7:0] d, input int gap);
        int t;
        byte_valid = 1'b0;
        byte_data  = d;
        t = 0;
        @(negedge clock);
        while (!byte_ready && t < 200) begin @(negedge clock); t++; end
        if (!byte_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: byte_ready=%b required 1 within 200 cycles", byte_ready);
            return;
        end
        if (gap > 0) begin repeat (gap) @(posedge clock); #1; end
        byte_valid = 1'b1;
        t = 0;
        while (!byte_ready && t < 200) begin @(negedge clock); t++; end
        @(posedge clock); #1;
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                            input int fault_rel, input bit poke);
        int sb, nb, t;
        logic [15:0] got, exp;
        exp = {b0, b1};
        @(negedge clock); #1;
        sb = shifts;
        nb = nr_low;
        fault_target = (fault_rel == 0) ? 0 : sb + fault_rel;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        checks++;
        if (fault !== 1'b0 || busy !== 1'b1 || grid_config_nreset !== 1'b0) begin
            errors++;
            $display("FAIL clear_entry: fault=%b busy=%b gnr=%b required 0 1 0", fault, busy, grid_config_nreset);
        end
        send_byte(b0, 0);
        if (poke) begin
            @(posedge clock); #1 start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
        end
        send_byte(b1, gap);
        t = 0;
        while (!done && t < 100) begin @(negedge clock); t++; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done=%b required 1 within 100 cycles", done);
        end
        #1;
        checks++;
        if (shifts - sb !== 16) begin
            errors++;
            $display("FAIL shift_count: got %0d required 16", shifts - sb);
        end
        checks++;
        if (nr_low - nb !== 4) begin
            errors++;
            $display("FAIL clear_cycles: got %0d required 4", nr_low - nb);
        end
        if (shifts - sb >= 16) begin
            for (int i = 0; i < 16; i++) got[15-i] = bits_q[sb+i];
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bit_sequence: got %b required %b", got, exp);
            end
            checks++;
            if (en_q[sb+15] - en_q[sb] !== 15 + gap) begin
                errors++;
                $display("FAIL shift_span: got %0d required %0d", en_q[sb+15] - en_q[sb], 15 + gap);
            end
            checks++;
            if (done_cyc !== en_q[sb+15] + 1) begin
                errors++;
                $display("FAIL done_timing: done at %0d required %0d", done_cyc, en_q[sb+15] + 1);
            end
        end
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || grid_config_nreset !== 1'b1) begin
            errors++;
            $display("FAIL done_outputs: busy=%b ready=%b gnr=%b required 0 0 1", busy, byte_ready, grid_config_nreset);
        end
        checks++;
        if (fault !== (fault_rel != 0)) begin
            errors++;
            $display("FAIL fault_in_done: got %b required %b", fault, fault_rel != 0);
        end
        if (fault_rel != 0) begin
            checks++;
            if (fault_rise_at !== sb + fault_rel) begin
                errors++;
                $display("FAIL fault_timing: rose after shift %0d required after shift %0d", fault_rise_at - sb, fault_rel);
            end
        end
        fault_target = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({byte_ready, grid_config_in, grid_config_enable, grid_config_nreset, busy, done, fault} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {byte_ready, grid_config_in, grid_config_enable, grid_config_nreset, busy, done, fault});
        end
        nreset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (grid_config_nreset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: gnr=%b busy=%b done=%b ready=%b required 1 0 0 0",
                     grid_config_nreset, busy, done, byte_ready);
        end
    endtask

    task automatic test_basic;         run_load(8'hA5, 8'h3C, 0, 0, 1'b0); endtask
    task automatic test_stall;         run_load(8'h96, 8'h0F, 3, 0, 1'b0); endtask
    task automatic test_fault;
        run_load(8'hC3, 8'h81, 0, 5, 1'b0);
        run_load(8'h12, 8'h34, 0, 0, 1'b0);
    endtask
    task automatic test_start_in_load; run_load(8'h5A, 8'hC3, 0, 0, 1'b1); endtask

    task automatic test_reset_mid_load;
        int sb, t;
        @(negedge clock); #1;
        sb = shifts;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        send_byte(8'hFF, 0);
        t = 0;
        @(negedge clock); #1;
        while (shifts - sb < 7 && t < 100) begin @(negedge clock); #1; t++; end
        @(posedge clock); #1 nreset = 1'b0;
        #1;
        checks++;
        if ({byte_ready, grid_config_in, grid_config_enable, grid_config_nreset, busy, done, fault} !== 7'b0) begin
            errors++;
            $display("FAIL midload_reset_outputs: got %b required 0000000",
                     {byte_ready, grid_config_in, grid_config_enable, grid_config_nreset, busy, done, fault});
        end
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        checks++;
        if (shifts - sb !== 7) begin
            errors++;
            $display("FAIL midload_abandon: shifts %0d required 7", shifts - sb);
        end
        run_load(8'hE7, 8'h18, 0, 0, 1'b0);
    endtask

    task automatic test_partial;
        int t;
        logic [11:0] got;
        @(posedge clock); #1 start12 = 1'b1;
        @(posedge clock); #1 start12 = 1'b0;
        bv12 = 1'b1;
        bd12 = 8'hFF;
        t = 0;
        @(negedge clock);
        while (!br12 && t < 100) begin @(negedge clock); t++; end
        @(posedge clock); #1 bd12 = 8'h9F;
        @(negedge clock);
        t = 0;
        while (!br12 && t < 100) begin @(negedge clock); t++; end
        @(posedge clock); #1 bd12 = 8'h77;
        t = 0;
        while (!done12 && t < 100) begin @(negedge clock); t++; end
        repeat (4) @(negedge clock);
        #1;
        checks++;
        if (acc12 !== 2) begin
            errors++;
            $display("FAIL partial_accepts: got %0d required 2", acc12);
        end
        checks++;
        if (bits12_q.size() !== 12) begin
            errors++;
            $display("FAIL partial_shift_count: got %0d required 12", bits12_q.size());
        end else begin
            for (int i = 0; i < 12; i++) got[11-i] = bits12_q[i];
            checks++;
            if (got !== 12'b111111111001) begin
                errors++;
                $display("FAIL partial_bits: got %b required 111111111001", got);
            end
        end
        checks++;
        if (done12 !== 1'b1 || br12 !== 1'b0 || fault12 !== 1'b0) begin
            errors++;
            $display("FAIL partial_done: done=%b ready=%b fault=%b required 1 0 0", done12, br12, fault12);
        end
        bv12 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_fault;
        test_start_in_load;
        test_partial;
        test_reset_mid_load;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all other ports SHALL be synchronous to the clock's rising edge.
REQ-002 Parameter CHAIN_LENGTH, default 5120: total configuration bits in the downstream logic grid chain, at least 1.
REQ-003 Parameter CLEAR_CYCLES, default 4: cycles grid_config_nreset is held low before loading, at least 1.
REQ-004 clock  input  1  system clock.
REQ-005 nreset  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a configuration load.
REQ-007 byte_data  input  8  bitstream byte, shifted out MSB first.
REQ-008 byte_valid  input  1  byte_data is valid.
REQ-009 byte_ready  output  1  block accepts byte_data this cycle.
REQ-010 grid_config_in  output  1  serial bit to the grid's config_in.
REQ-011 grid_config_enable  output  1  shift strobe to the grid's config_enable.
REQ-012 grid_config_nreset  output  1  active-low chain clear to the grid's config_nreset.
REQ-013 grid_config_out  input  1  chain tail returned from the grid's config_out.
REQ-014 busy  output  1  high in CLEAR or LOAD.
REQ-015 done  output  1  high in DONE.
REQ-016 fault  output  1  sticky chain-integrity error for the current or last load.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, LOAD and DONE.
REQ-018 On start in IDLE or DONE, the FSM SHALL enter CLEAR on the next edge, clear fault, and load the bit counter with CHAIN_LENGTH.
- start SHALL be ignored in CLEAR and LOAD.
REQ-019 In CLEAR, grid_config_nreset SHALL be 0 for exactly CLEAR_CYCLES cycles, then the FSM SHALL enter LOAD.
- grid_config_nreset SHALL be 1 in all other states.
REQ-020 Handshake: a byte SHALL transfer on any edge where byte_valid and byte_ready are both 1.
- byte_ready SHALL be 1 only in LOAD, only when bits remain unloaded beyond those already in the shift register, and only when the shift register is empty or shifting its final valid bit.
- This allows back-to-back bytes with no bubble.
REQ-021 Each accepted byte SHALL produce one shift cycle per bit, starting the cycle after acceptance.
- In each shift cycle: grid_config_enable=1, grid_config_in=current MSB; the bit counter decrements by 1.
REQ-022 grid_config_enable SHALL be 0 in every non-shift cycle, including stalls caused by byte_valid=0; grid_config_in SHALL be 0 when grid_config_enable is 0.
REQ-023 Final partial byte: when r = CHAIN_LENGTH mod 8 is nonzero, only the r MSBs of the final byte SHALL be shifted; its remaining bits SHALL be discarded.
REQ-024 Total shift cycles per load SHALL equal exactly CHAIN_LENGTH.
- The total number of bytes accepted SHALL equal ceil(CHAIN_LENGTH/8).
- Bytes offered after the last one SHALL not be accepted.
REQ-025 Integrity check: in every shift cycle, grid_config_out SHALL be sampled; a sampled 1 SHALL set fault, since the chain was just cleared.
- fault SHALL remain 1 until the next accepted start or reset.
REQ-026 On the edge completing the CHAIN_LENGTH-th shift, the FSM SHALL enter DONE.
- In DONE: done=1, busy=0, byte_ready=0.
- The FSM SHALL remain in DONE until start.
REQ-027 The bit counter SHALL be clog2(CHAIN_LENGTH+1) bits wide and SHALL never wrap.

Reset
REQ-028 While nreset=0, the FSM SHALL be forced to IDLE; the shift register and counters SHALL clear; outputs SHALL be: byte_ready=0, grid_config_in=0, grid_config_enable=0, grid_config_nreset=0, busy=0, done=0, fault=0.
REQ-029 After nreset deasserts, grid_config_nreset SHALL be 1 from the first clock edge onward in IDLE.
REQ-030 Reset asserted mid-CLEAR or mid-LOAD SHALL abandon the load with no further shift strobes; a subsequent start SHALL begin a full load from CLEAR.

Verification
REQ-031 CHAIN_LENGTH=16, CLEAR_CYCLES=4; start, then bytes 0xA5, 0x3C with valid always high -> grid_config_nreset low for 4 cycles; then 16 consecutive enable cycles with bits 1010010100111100; done=1 on the next cycle; fault=0.
REQ-032 CHAIN_LENGTH=12; bytes 0xFF, 0x9F -> 12 shifts with bits 111111111001; exactly 2 bytes accepted; a third offered byte is never accepted.
REQ-033 CHAIN_LENGTH=16; byte_valid deasserted for 3 cycles between bytes -> enable low for those 3 cycles; bit order unchanged; total enable cycles = 16.
REQ-034 grid_config_out forced to 1 on the 5th shift cycle only -> fault=1 from the next cycle, held through DONE; the next start clears fault to 0.
REQ-035 nreset pulsed low after the 7th shift -> all outputs take their reset values immediately; start then re-runs CLEAR; a full 16-bit load completes normally.
REQ-036 start asserted during LOAD -> no effect on the shift count or bit sequence.
